spram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 16K×32 single-port SPRAM (`ram16Kx32`). It accepts word accesses from two masters over picorv32-style valid/ready native memory ports, typically the CPU on port 0 and a DMA or video fetcher on port 1. It grants one access at a time in round-robin order and drives the RAM's `cs`/`wren`/`adr`/`di`. It also captures `do` in the one cycle it is valid, because the RAM pulls its outputs low whenever `cs` is low.

---
 rtl/spram_arbiter.sv | 82 ++++++++
 tb/tb_spram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// spram_arbiter: round-robin two-master sequencer for a single-port SRAM with 1-cycle read latency
module spram_arbiter #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_valid,
    input  logic [AW-1:0] m0_addr,
    input  logic [3:0]    m0_wstrb,
    input  logic [31:0]   m0_wdata,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    input  logic [AW-1:0] m1_addr,
    input  logic [3:0]    m1_wstrb,
    input  logic [31:0]   m1_wdata,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,
    output logic          busy,
    output logic          ram_cs,
    output logic [3:0]    ram_wren,
    output logic [AW-1:0] ram_adr,
    output logic [31:0]   ram_di,
    input  logic [31:0]   ram_do
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
    state_t state, state_next;
    logic grant, last, sel, req;
    logic [31:0] rdata;
    assign m0_rdata = rdata;
    assign m1_rdata = rdata;
    always_comb begin
        req = m0_valid | m1_valid;
        sel = (m0_valid && m1_valid) ? ~last : m1_valid;
        state_next = state;
        case (state)
            IDLE:    state_next = req ? ACCESS : IDLE;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_next;
    // ram_do is only valid while cs is still high, so it is captured in CAPTURE before cs drops
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            grant    <= 1'b0;
            last     <= 1'b1;
            ram_cs   <= 1'b0;
            ram_wren <= '0;
            ram_adr  <= '0;
            ram_di   <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            rdata    <= '0;
        end else begin
            busy <= state_next != IDLE;
            case (state)
                IDLE: if (req) begin
                    grant    <= sel;
                    ram_cs   <= 1'b1;
                    ram_adr  <= sel ? m1_addr : m0_addr;
                    ram_di   <= sel ? m1_wdata : m0_wdata;
                    ram_wren <= sel ? m1_wstrb : m0_wstrb;
                end
                ACCESS: ram_wren <= '0;
                CAPTURE: begin
                    rdata    <= ram_do;
                    m0_ready <= ~grant;
                    m1_ready <= grant;
                    ram_cs   <= 1'b0;
                end
                default: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    last     <= grant;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: randomized self-checking bench with a RAM model and a reference memory
module tb_spram_arbiter;
    logic clk = 0, rst = 1;
    logic m0_valid = 0, m1_valid = 0;
    logic [13:0] m0_addr = 0, m1_addr = 0;
    logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic m0_ready, m1_ready, busy, ram_cs;
    logic [31:0] m0_rdata, m1_rdata, ram_di, ram_do;
    logic [3:0] ram_wren;
    logic [13:0] ram_adr;
    logic [31:0] mem [16384];
    logic [31:0] ref_mem [16384];
    logic [31:0] rd_q = 0;
    int total = 0, passed = 0;

    spram_arbiter #(.AW(14)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .busy(busy), .ram_cs(ram_cs), .ram_wren(ram_wren), .ram_adr(ram_adr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // RAM model: 1-cycle read latency, byte-masked writes, outputs forced low while cs is low
    always @(posedge clk) begin
        if (ram_cs) begin
            rd_q <= mem[ram_adr];
            for (int b = 0; b < 4; b++)
                if (ram_wren[b]) mem[ram_adr][8*b +: 8] <= ram_di[8*b +: 8];
        end
    end
    assign ram_do = ram_cs ? rd_q : 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic set_port(input int p, input logic v, input logic [13:0] a, input logic [3:0] s, input logic [31:0] d);
        if (p == 0) begin
            m0_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = d;
        end else begin
            m1_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = d;
        end
    endtask

    // one access on port p; reports what was observed cycle by cycle from the request cycle on
    task automatic run_txn(input int p, input logic [13:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] r, output int lat, output int cs_cnt, output int other,
                           output logic [3:0] wren_acc, output int wren_bad);
        lat = -1; cs_cnt = 0; other = 0; wren_acc = 0; wren_bad = 0; r = 0;
        set_port(p, 1, a, s, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cs_cnt += int'(ram_cs);
            other += int'(p == 0 ? m1_ready : m0_ready);
            if (i == 1) wren_acc = ram_wren;
            else if (ram_wren != 0) wren_bad++;
            if ((p == 0 ? m0_ready : m1_ready) === 1'b1) begin
                r = p == 0 ? m0_rdata : m1_rdata;
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        set_port(p, 0, a, s, d);
        if (s != 0) ref_mem[a] = merge(ref_mem[a], s, d);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({ram_cs, ram_wren, ram_adr, ram_di, m0_ready, m1_ready, m0_rdata, busy} !== '0)
            $display("FAIL reset_outputs: cs=%b wren=%b adr=%h di=%h rdy=%b%b rdata=%h busy=%b want all zero",
                     ram_cs, ram_wren, ram_adr, ram_di, m0_ready, m1_ready, m0_rdata, busy);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input int p, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r; logic [3:0] wa; int lat, cs, oth, wb;
        logic [31:0] want;
        run_txn(p, 14'h0005, s, d, r, lat, cs, oth, wa, wb);
        total++; if (lat !== 3) $display("FAIL p%0d_write_latency: got %0d want 3", p, lat); else passed++;
        total++; if (wa !== s) $display("FAIL p%0d_write_wren: got %b want %b", p, wa, s); else passed++;
        want = ref_mem[5];
        run_txn(p, 14'h0005, 4'b0000, 32'h0, r, lat, cs, oth, wa, wb);
        total++; if (lat !== 3) $display("FAIL p%0d_read_latency: got %0d want 3", p, lat); else passed++;
        total++; if (r !== want) $display("FAIL p%0d_read_data: got %h want %h", p, r, want); else passed++;
        total++; if (oth !== 0) $display("FAIL p%0d_other_ready: got %0d pulses want 0", p, oth); else passed++;
        total++; if (cs !== 2) $display("FAIL p%0d_cs_cycles: got %0d want 2", p, cs); else passed++;
    endtask

    task automatic test_round_robin();
        int ports[$], cycs[$];
        logic [31:0] datas[$];
        do_reset();
        set_port(0, 1, 14'h0005, 0, 0);
        set_port(1, 1, 14'h3FFF, 0, 0);
        for (int c = 0; c < 40 && ports.size() < 4; c++) begin
            @(negedge clk);
            if (m0_ready && m1_ready) begin
                total++; $display("FAIL rr_both_ready: cycle %0d both readies high", c);
            end
            if (m0_ready || m1_ready) begin
                ports.push_back(m1_ready ? 1 : 0);
                cycs.push_back(c);
                datas.push_back(m0_rdata);
            end
        end
        @(posedge clk); #1;
        m0_valid = 0; m1_valid = 0;
        total++;
        if (ports.size() != 4) $display("FAIL rr_count: got %0d services want 4", ports.size());
        else begin
            passed++;
            total++; if (cycs[0] !== 3) $display("FAIL rr_first_latency: got %0d want 3", cycs[0]); else passed++;
            for (int k = 0; k < 4; k++) begin
                total++;
                if (ports[k] !== k % 2) $display("FAIL rr_order_%0d: got m%0d want m%0d", k, ports[k], k % 2);
                else passed++;
                total++;
                if (datas[k] !== ref_mem[k % 2 ? 14'h3FFF : 14'h0005])
                    $display("FAIL rr_data_%0d: got %h want %h", k, datas[k], ref_mem[k % 2 ? 14'h3FFF : 14'h0005]);
                else passed++;
                if (k > 0) begin
                    total++;
                    if (cycs[k] - cycs[k-1] !== 4) $display("FAIL rr_spacing_%0d: got %0d want 4", k, cycs[k] - cycs[k-1]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_continuous_p1();
        logic [31:0] r; logic [3:0] wa; int lat, cs, oth, wb;
        int readies = 0, cs_hi = 0, wren_nz = 0, bad_data = 0, n = 0;
        logic [13:0] a;
        run_txn(0, 14'h3FFF, 4'b1111, 32'hA5A5_0F0F, r, lat, cs, oth, wa, wb);
        run_txn(0, 14'h0000, 4'b1111, 32'h0BAD_CAFE, r, lat, cs, oth, wa, wb);
        a = 14'h3FFF;
        set_port(1, 1, a, 0, 0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            cs_hi += int'(ram_cs);
            if (ram_wren != 0) wren_nz++;
            if (m1_ready) begin
                readies++;
                if (m1_rdata !== ref_mem[a]) bad_data++;
            end
            @(posedge clk); #1;
            if (readies != n) begin
                n = readies;
                a = (n >= 2) ? 14'h0000 : 14'h3FFF;
                m1_addr = a;
            end
        end
        m1_valid = 0;
        total++; if (readies !== 4) $display("FAIL cont_readies: got %0d want 4", readies); else passed++;
        total++; if (cs_hi !== 8) $display("FAIL cont_cs_cycles: got %0d want 8", cs_hi); else passed++;
        total++; if (wren_nz !== 0) $display("FAIL cont_wren: got %0d nonzero cycles want 0", wren_nz); else passed++;
        total++; if (bad_data !== 0) $display("FAIL cont_data: got %0d bad reads want 0", bad_data); else passed++;
    endtask

    task automatic test_reset_capture();
        logic [31:0] r; logic [3:0] wa; int lat, cs, oth, wb, rdy = 0;
        set_port(0, 1, 14'h0005, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        set_port(0, 0, 14'h0005, 0, 0);
        @(negedge clk);
        total++;
        if (ram_cs !== 0 || busy !== 0) $display("FAIL rstcap_idle: cs=%b busy=%b want 0 0", ram_cs, busy);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            rdy += int'(m0_ready | m1_ready);
            @(negedge clk);
        end
        total++; if (rdy !== 0) $display("FAIL rstcap_ready: got %0d pulses want 0", rdy); else passed++;
        @(posedge clk); #1;
        run_txn(0, 14'h0005, 0, 0, r, lat, cs, oth, wa, wb);
        total++; if (lat !== 3) $display("FAIL rstcap_next_latency: got %0d want 3", lat); else passed++;
        total++; if (r !== ref_mem[5]) $display("FAIL rstcap_next_data: got %h want %h", r, ref_mem[5]); else passed++;
    endtask

    task automatic test_reset_access();
        logic [31:0] r; logic [3:0] wa; int lat, cs, oth, wb, rdy = 0;
        set_port(0, 1, 14'h0100, 4'b1111, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        set_port(0, 0, 14'h0100, 0, 0);
        ref_mem[14'h0100] = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rdy += int'(m0_ready | m1_ready);
        end
        total++; if (rdy !== 0) $display("FAIL rstacc_ready: got %0d pulses want 0", rdy); else passed++;
        @(posedge clk); #1;
        run_txn(0, 14'h0100, 0, 0, r, lat, cs, oth, wa, wb);
        total++; if (r !== ref_mem[14'h0100]) $display("FAIL rstacc_commit: got %h want %h", r, ref_mem[14'h0100]); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] r, d, want; logic [3:0] wa, s; logic [13:0] a; int lat, cs, oth, wb, p;
        for (int n = 0; n < 24; n++) begin
            p = int'($urandom_range(0, 1));
            a = 14'(16 + $urandom_range(0, 7));
            s = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
            d = $urandom;
            want = ref_mem[a];
            run_txn(p, a, s, d, r, lat, cs, oth, wa, wb);
            total++;
            if (lat !== 3 || oth !== 0 || cs !== 2 || wa !== s || wb !== 0)
                $display("FAIL rand_%0d_timing: p%0d lat=%0d other=%0d cs=%0d wren=%b bad=%0d want 3 0 2 %b 0",
                         n, p, lat, oth, cs, wa, wb, s);
            else passed++;
            if (s == 0) begin
                total++;
                if (r !== want) $display("FAIL rand_%0d_data: p%0d addr %h got %h want %h", n, p, a, r, want);
                else passed++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 0;
            ref_mem[i] = 0;
        end
        test_reset();
        test_basic(0, 4'b1111, 32'hDEAD_BEEF);
        test_basic(1, 4'b0010, 32'h0000_AA00);
        total++;
        if (ref_mem[5] !== 32'hDEAD_AAEF) $display("FAIL partial_model: got %h want deadaaef", ref_mem[5]);
        else passed++;
        test_round_robin();
        test_continuous_p1();
        test_reset_capture();
        test_reset_access();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
